// File: rtl/pe_pkg.sv
// Shared definitions for the PE feeder: FSM state encoding and default
// datapath/window/latency sizes.
package pe_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int LEN_W_DEF  = 8;
   localparam int PE_LAT_DEF = 1;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      DRAIN,
      HOLD
   } state_t;

endpackage

// File: rtl/pe_feeder_ctrl.sv
// Window sequencer for pe_feeder: FSM with the operand countdown (remain)
// and the drain countdown that waits out the PE pipeline.
module pe_feeder_ctrl
   import pe_pkg::*;
#(
   parameter int LEN_W  = LEN_W_DEF,
   parameter int PE_LAT = PE_LAT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             fire,
   input  logic             psum_ready,
   output logic             busy,
   output logic             stream,
   output logic             pe_en,
   output logic             pe_clr,
   output logic             capture,
   output logic             psum_valid,
   output logic             done
);

   localparam int CNT_W = $clog2(PE_LAT + 2);

   state_t             state;
   logic [LEN_W-1:0]   remain;
   logic [CNT_W-1:0]   drain_cnt;

   // Drain counter is preloaded in CLEAR so both STREAM and the len=0 path enter DRAIN ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         remain    <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  remain <= len;
                  state  <= CLEAR;
               end
            end
            CLEAR: begin
               drain_cnt <= CNT_W'(PE_LAT);
               state     <= (remain == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
               if (fire) begin
                  remain <= remain - 1'b1;
                  if (remain == LEN_W'(1)) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  state <= HOLD;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            HOLD: begin
               if (psum_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy       = (state != IDLE);
   assign stream     = (state == STREAM);
   assign pe_en      = (state == STREAM) || (state == DRAIN);
   assign pe_clr     = (state == CLEAR);
   assign capture    = (state == DRAIN) && (drain_cnt == '0);
   assign psum_valid = (state == HOLD);
   assign done       = (state == HOLD) && psum_ready;

endmodule

// File: rtl/pe_feeder.sv
// Operand sequencer for one PE: joint ifmap/filter handshake, window clear,
// drain and psum return. Optional product-overflow flag via PE_FEEDER_OVF_EN.
module pe_feeder
   import pe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF,
   parameter int PE_LAT = PE_LAT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   input  logic              ifmap_valid,
   input  logic [DATA_W-1:0] ifmap_data,
   output logic              ifmap_ready,
   input  logic              filter_valid,
   input  logic [DATA_W-1:0] filter_data,
   output logic              filter_ready,
   output logic [DATA_W-1:0] pe_ifmap,
   output logic [DATA_W-1:0] pe_filter,
   output logic              pe_en,
   output logic              pe_clr,
   input  logic [DATA_W-1:0] pe_psum,
   output logic              psum_valid,
   output logic [DATA_W-1:0] psum_data,
   input  logic              psum_ready,
   output logic              done
`ifdef PE_FEEDER_OVF_EN
   ,
   output logic              ovf
`endif
);

   logic stream;
   logic capture;
   logic fire;

   // Both streams advance together; a lone valid never consumes its word
   assign fire         = stream && ifmap_valid && filter_valid;
   assign ifmap_ready  = fire;
   assign filter_ready = fire;

   pe_feeder_ctrl #(
      .LEN_W  (LEN_W),
      .PE_LAT (PE_LAT)
   ) u_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len),
      .fire       (fire),
      .psum_ready (psum_ready),
      .busy       (busy),
      .stream     (stream),
      .pe_en      (pe_en),
      .pe_clr     (pe_clr),
      .capture    (capture),
      .psum_valid (psum_valid),
      .done       (done)
   );

   // Non-fire cycles feed zeros so bubbles and the drain add nothing to the sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_ifmap  <= '0;
         pe_filter <= '0;
         psum_data <= '0;
      end else begin
         pe_ifmap  <= fire ? ifmap_data  : '0;
         pe_filter <= fire ? filter_data : '0;
         if (capture) begin
            psum_data <= pe_psum;
         end
      end
   end

`ifdef PE_FEEDER_OVF_EN
   logic [2*DATA_W-1:0] product;

   assign product = {{DATA_W{1'b0}}, ifmap_data} * {{DATA_W{1'b0}}, filter_data};

   // Sticky per window: any fired pair whose full product exceeds DATA_W bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (pe_clr) begin
         ovf <= 1'b0;
      end else if (fire && (|product[2*DATA_W-1:DATA_W])) begin
         ovf <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/pe_feeder.md
# pe_feeder

Operand sequencer that drives a single `pe` instance.

- Accepts paired ifmap/filter operand streams over valid/ready handshakes.
- Clears the PE accumulator at the start of each window and issues exactly `len` products into it.
- Waits out the PE pipeline latency, then captures the accumulated psum and returns it on a valid/ready output.
- Sits between the on-chip operand buffers and a `pe`; one feeder per PE in the array.

## Interface

Parameters:
- `DATA_W`, 16: operand and psum width; matches the `pe` ports.
- `LEN_W`, 8: width of the window length.
- `PE_LAT`, 1: registered stages inside the PE between operand input and psum output.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a window; sampled only in IDLE.
- `len` in `LEN_W`: number of operand pairs; sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `ifmap_valid` in 1 / `ifmap_data` in `DATA_W` / `ifmap_ready` out 1: ifmap operand stream.
- `filter_valid` in 1 / `filter_data` in `DATA_W` / `filter_ready` out 1: filter operand stream.
- `pe_ifmap` out `DATA_W`, `pe_filter` out `DATA_W`: registered operands to the PE.
- `pe_en` out 1: PE enable.
- `pe_clr` out 1: PE accumulator clear; active-high, drives the PE `rst`.
- `pe_psum` in `DATA_W`: PE `output_psum`.
- `psum_valid` out 1 / `psum_data` out `DATA_W` / `psum_ready` in 1: result stream.
- `done` out 1: one-cycle pulse on result handshake.

## Operation

States and transitions:
- IDLE: `start` → CLEAR. Latch `len` into `remain`.
- CLEAR: exactly 1 cycle, `pe_clr`=1. Then → STREAM, or → DRAIN if `remain`==0.
- STREAM: `pe_en`=1.
  - fire = `ifmap_valid & filter_valid`.
  - `ifmap_ready` = `filter_ready` = fire. Joint handshake: neither stream is consumed alone.
  - On fire: register both data words into `pe_ifmap`/`pe_filter` and decrement `remain`.
  - On a non-fire cycle: register 0 into both, so a bubble adds a zero product.
  - The fire that brings `remain` to 0 → DRAIN.
- DRAIN: `pe_en`=1, operands 0, lasts PE_LAT+1 cycles (down-counter). Last cycle: `psum_data` ← `pe_psum` → HOLD.
- HOLD: `psum_valid`=1, `psum_data` stable, `pe_en`=0. On `psum_ready` → IDLE with `done`=1 that cycle.

Rules and boundary conditions:
- Ready is 0 in every state but STREAM; `start` outside IDLE is ignored.
- Arithmetic is performed in the PE. Its result is the low `DATA_W` bits of the product, and accumulation wraps modulo 2^`DATA_W`. The feeder does not alter it.
- `len`=0: CLEAR, DRAIN, HOLD, and the result is 0.
- `len`=2^`LEN_W`−1 is legal; `remain` has width `LEN_W`.
- `rst_n` low at any time, mid-window included:
  - Immediate return to IDLE.
  - All outputs 0, counters 0, and the partial result is discarded.
  - The next window starts with CLEAR, so PE residue is harmless.

## Timing

- Reset values: `busy`, `ifmap_ready`, `filter_ready`, `pe_ifmap`, `pe_filter`, `pe_en`, `pe_clr`, `psum_valid`, `psum_data`, `done` all 0.
- Operand latency: a fire in cycle t appears on `pe_ifmap`/`pe_filter` in cycle t+1.
- A window with no bubbles reaches HOLD at cycle 1 (CLEAR) + len (STREAM) + PE_LAT+1 (DRAIN), counted from the cycle after `start` is sampled.
- `psum_valid` can be high at the earliest on the cycle after the last DRAIN cycle. It is held until `psum_ready`.
- `done` is combinational on the HOLD handshake.
- Back-to-back windows: `start` is accepted on the cycle after `done`.

## Configuration

- `PE_FEEDER_OVF_EN` defined:
  - Adds output `ovf` (1 bit, reset 0).
  - Set if any fired pair's full 2·`DATA_W` product has nonzero upper `DATA_W` bits.
  - Cleared in CLEAR; valid alongside `psum_valid`.
- Undefined: no port, no multiplier in the feeder.

## Structure

- Shared package `pe_pkg`:
  - State enum: IDLE, CLEAR, STREAM, DRAIN, HOLD.
  - Default `DATA_W`/`LEN_W`/`PE_LAT` constants.
- One natural sub-module, `pe_feeder_ctrl`: FSM plus `remain`/drain counters. The datapath registers stay in `pe_feeder`.

## Test plan

- len=3, pairs (2,3),(4,5),(1,7) offered back-to-back, `psum_ready`=1 → `psum_data`=33, `done` one pulse, cycle count per Timing.
- Same pairs with `filter_valid` low 2 cycles between pairs 1 and 2 → no handshake while either valid is low, result still 33, HOLD reached 2 cycles later.
- len=0 → `psum_valid` with `psum_data`=0; `ifmap_ready` never asserted.
- `psum_ready` held low 5 cycles in HOLD → `psum_data` stable, `start` ignored, handshake on cycle 6 then IDLE.
- `rst_n` pulsed low after 2 of 4 pairs → all outputs 0 immediately; new window len=1, (3,3) → 9.
- With `PE_FEEDER_OVF_EN`, len=1, (300,300) → `ovf`=1, `psum_data`=90000 mod 65536=24464; next window (2,2) → `ovf`=0.
